// File: rtl/alu_decode_stage_if.sv
// Handshake and payload bundle between the register-read side, the ALU
// decode stage and the execute side.
//   i_flush                  : drop every buffered entry this cycle
//   i_valid / o_in_ready     : upstream handshake (instruction + operands)
//   i_inst, i_pc             : instruction word and its address
//   i_rs1_data, i_rs2_data   : register-file read data
//   o_valid / i_ready        : downstream handshake (decoded entry)
//   o_alu1, o_alu2           : ALU operands
//   o_alu_sel                : ALU operation select
//   o_rd, o_we               : destination register and writeback enable
//   o_illegal                : entry is not a legal integer-ALU instruction
// modport slave  : the decode stage itself
// modport master : whoever drives the stage (upstream and execute side)
interface alu_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 4
);
  logic             i_flush;
  logic             i_valid;
  logic             o_in_ready;
  logic [31:0]      i_inst;
  logic [XLEN-1:0]  i_pc;
  logic [XLEN-1:0]  i_rs1_data;
  logic [XLEN-1:0]  i_rs2_data;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_alu1;
  logic [XLEN-1:0]  o_alu2;
  logic [SEL_W-1:0] o_alu_sel;
  logic [4:0]       o_rd;
  logic             o_we;
  logic             o_illegal;

  modport slave (
    input  i_flush, i_valid, i_inst, i_pc, i_rs1_data, i_rs2_data, i_ready,
    output o_in_ready, o_valid, o_alu1, o_alu2, o_alu_sel, o_rd, o_we, o_illegal
  );

  modport master (
    output i_flush, i_valid, i_inst, i_pc, i_rs1_data, i_rs2_data, i_ready,
    input  o_in_ready, o_valid, o_alu1, o_alu2, o_alu_sel, o_rd, o_we, o_illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I integer-ALU decode/issue stage. Decodes OP, OP-IMM, LUI and AUIPC
// into an operand pair plus ALU select, and buffers the result in an output
// register backed by a one-entry skid register (two entries total, FIFO).
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous reset, active-high
//   bus   : alu_decode_stage_if.slave (handshakes, instruction, operands,
//           decoded outputs)
module alu_decode_stage #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  alu_decode_stage_if.slave    bus
);

  localparam logic [SEL_W-1:0] SEL_ADD  = SEL_W'(4'b0000);
  localparam logic [SEL_W-1:0] SEL_SUB  = SEL_W'(4'b0001);
  localparam logic [SEL_W-1:0] SEL_SLL  = SEL_W'(4'b0010);
  localparam logic [SEL_W-1:0] SEL_SLT  = SEL_W'(4'b0011);
  localparam logic [SEL_W-1:0] SEL_SLTU = SEL_W'(4'b0100);
  localparam logic [SEL_W-1:0] SEL_XOR  = SEL_W'(4'b0101);
  localparam logic [SEL_W-1:0] SEL_SRL  = SEL_W'(4'b0110);
  localparam logic [SEL_W-1:0] SEL_SRA  = SEL_W'(4'b0111);
  localparam logic [SEL_W-1:0] SEL_OR   = SEL_W'(4'b1000);
  localparam logic [SEL_W-1:0] SEL_AND  = SEL_W'(4'b1001);
  localparam logic [SEL_W-1:0] SEL_PASS = SEL_W'(4'b1111);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0]  alu1;
    logic [XLEN-1:0]  alu2;
    logic [SEL_W-1:0] sel;
    logic [4:0]       rd;
    logic             we;
    logic             illegal;
  } entry_t;

  function automatic entry_t decode(input logic [31:0]     inst,
                                    input logic [XLEN-1:0] pc,
                                    input logic [XLEN-1:0] rs1,
                                    input logic [XLEN-1:0] rs2);
    entry_t                  e;
    logic                    legal;
    logic                    f7_base;
    logic                    f7_alt;
    logic signed [XLEN-1:0]  imm_i;
    logic signed [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]         shamt_r;
    logic [XLEN-1:0]         shamt_i;
    e       = '0;
    legal   = 1'b0;
    f7_base = (inst[31:25] == 7'b0000000);
    f7_alt  = (inst[31:25] == 7'b0100000);
    imm_i   = XLEN'($signed(inst[31:20]));
    imm_u   = XLEN'($signed({inst[31:12], 12'b0}));
    // The ALU shifts by its whole second operand, so only the 5-bit
    // shift amount may reach it.
    shamt_r = XLEN'(rs2[4:0]);
    shamt_i = XLEN'(inst[24:20]);
    case (inst[6:0])
      OPC_OP: begin
        e.alu1 = rs1;
        e.alu2 = rs2;
        case (inst[14:12])
          3'b000: begin legal = f7_base | f7_alt; e.sel = f7_alt ? SEL_SUB : SEL_ADD; end
          3'b001: begin legal = f7_base; e.sel = SEL_SLL; e.alu2 = shamt_r; end
          3'b010: begin legal = f7_base; e.sel = SEL_SLT; end
          3'b011: begin legal = f7_base; e.sel = SEL_SLTU; end
          3'b100: begin legal = f7_base; e.sel = SEL_XOR; end
          3'b101: begin legal = f7_base | f7_alt; e.sel = f7_alt ? SEL_SRA : SEL_SRL; e.alu2 = shamt_r; end
          3'b110: begin legal = f7_base; e.sel = SEL_OR; end
          default: begin legal = f7_base; e.sel = SEL_AND; end
        endcase
      end
      OPC_IMM: begin
        e.alu1 = rs1;
        e.alu2 = imm_i;
        case (inst[14:12])
          3'b000: begin legal = 1'b1; e.sel = SEL_ADD; end
          3'b001: begin legal = f7_base; e.sel = SEL_SLL; e.alu2 = shamt_i; end
          3'b010: begin legal = 1'b1; e.sel = SEL_SLT; end
          3'b011: begin legal = 1'b1; e.sel = SEL_SLTU; end
          3'b100: begin legal = 1'b1; e.sel = SEL_XOR; end
          3'b101: begin legal = f7_base | f7_alt; e.sel = f7_alt ? SEL_SRA : SEL_SRL; e.alu2 = shamt_i; end
          3'b110: begin legal = 1'b1; e.sel = SEL_OR; end
          default: begin legal = 1'b1; e.sel = SEL_AND; end
        endcase
      end
      OPC_LUI: begin
        legal  = 1'b1;
        e.alu1 = '0;
        e.alu2 = imm_u;
        e.sel  = SEL_PASS;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        e.alu1 = pc;
        e.alu2 = imm_u;
        e.sel  = SEL_ADD;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.alu1 = '0;
      e.alu2 = '0;
      e.sel  = SEL_PASS;
    end
    e.rd      = inst[11:7];
    e.we      = legal && (inst[11:7] != 5'd0);
    e.illegal = !legal;
    return e;
  endfunction

  entry_t ent_p0;
  entry_t out_p1;
  entry_t skid_p1;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   accept;
  logic   xfer;
  logic   out_free;

  // ---- stage p0: combinational decode of the incoming instruction ----
  assign ent_p0 = decode(bus.i_inst, bus.i_pc, bus.i_rs1_data, bus.i_rs2_data);

  assign bus.o_in_ready = !skid_vld_p1 && !i_rst;
  assign accept         = bus.i_valid && bus.o_in_ready;
  assign xfer           = vld_p1 && bus.i_ready;
  assign out_free       = !vld_p1 || xfer;

  // ---- stage p1: output register (older) + skid register (younger) ----
  // The skid only fills while the output register is held, so whenever the
  // output register frees up the skid entry (if any) moves forward and no
  // accept can be pending at the same time (o_in_ready was low).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (bus.i_flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (out_free) begin
      vld_p1      <= skid_vld_p1 || accept;
      skid_vld_p1 <= 1'b0;
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // Output payload is cleared on reset so the outputs read as zero until
  // the first entry loads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_p1 <= '0;
    end else if (!bus.i_flush && out_free) begin
      if (skid_vld_p1) begin
        out_p1 <= skid_p1;
      end else if (accept) begin
        out_p1 <= ent_p0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept && !out_free) begin
      skid_p1 <= ent_p0;
    end
  end

  assign bus.o_valid   = vld_p1;
  assign bus.o_alu1    = out_p1.alu1;
  assign bus.o_alu2    = out_p1.alu2;
  assign bus.o_alu_sel = out_p1.sel;
  assign bus.o_rd      = out_p1.rd;
  assign bus.o_we      = out_p1.we;
  assign bus.o_illegal = out_p1.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: directed decode vectors, stall/flush/reset
// scenarios and a randomized stream checked against a two-deep FIFO model.
module tb_alu_decode_stage;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  alu_decode_stage_if #(.XLEN(32), .SEL_W(4)) ifc ();

  alu_decode_stage #(.XLEN(32), .SEL_W(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (ifc)
  );

  typedef struct packed {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  // Select per funct3 for the non-alternate encodings:
  // ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [3:0] OP_SEL [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  exp_t q[$];
  int   tests_run = 0;
  int   fails     = 0;

  function automatic exp_t got();
    return {ifc.o_alu1, ifc.o_alu2, ifc.o_alu_sel, ifc.o_rd, ifc.o_we, ifc.o_illegal};
  endfunction

  // Reference decode, written from the instruction-level rules.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t       r;
    int         f3;
    logic [6:0] op;
    logic [6:0] f7;
    bit         ok;
    bit         is_shift;
    op       = inst[6:0];
    f3       = int'(inst[14:12]);
    f7       = inst[31:25];
    r        = '0;
    r.rd     = inst[11:7];
    ok       = 1'b0;
    is_shift = (f3 == 1) || (f3 == 5);
    if (op == 7'h33) begin
      r.a1  = rs1;
      r.a2  = is_shift ? (rs2 % 32) : rs2;
      r.sel = OP_SEL[f3];
      if (f7 == 7'h00) ok = 1'b1;
      else if (f7 == 7'h20 && f3 == 0) begin ok = 1'b1; r.sel = 4'd1; end
      else if (f7 == 7'h20 && f3 == 5) begin ok = 1'b1; r.sel = 4'd7; end
    end else if (op == 7'h13) begin
      r.a1  = rs1;
      r.sel = OP_SEL[f3];
      if (is_shift) begin
        r.a2 = (inst >> 20) % 32;
        ok   = (f7 == 7'h00) || (f3 == 5 && f7 == 7'h20);
        if (f3 == 5 && f7 == 7'h20) r.sel = 4'd7;
      end else begin
        r.a2 = {{20{inst[31]}}, inst[31:20]};
        ok   = 1'b1;
      end
    end else if (op == 7'h37) begin
      ok = 1'b1; r.a1 = '0; r.a2 = inst & 32'hFFFF_F000; r.sel = 4'hF;
    end else if (op == 7'h17) begin
      ok = 1'b1; r.a1 = pc; r.a2 = inst & 32'hFFFF_F000; r.sel = 4'h0;
    end
    if (!ok) begin
      r.a1 = '0; r.a2 = '0; r.sel = 4'hF;
    end
    r.ill = !ok;
    r.we  = ok && (r.rd != 5'd0);
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [5];
    int          k;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63};
    w = $urandom;
    k = int'($urandom_range(0, 5));
    if (k < 5) w[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0, 1:    w[31:25] = 7'h00;
      2:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    ifc.i_valid    = v;
    ifc.i_inst     = inst;
    ifc.i_pc       = pc;
    ifc.i_rs1_data = rs1;
    ifc.i_rs2_data = rs2;
  endtask

  // Advance one clock and keep the FIFO model in step with it.
  task automatic cycle();
    bit   acc;
    bit   xf;
    exp_t e;
    acc = ifc.i_valid && ifc.o_in_ready;
    xf  = ifc.o_valid && ifc.i_ready;
    e   = ref_decode(ifc.i_inst, ifc.i_pc, ifc.i_rs1_data, ifc.i_rs2_data);
    @(posedge i_clk);
    if (i_rst || ifc.i_flush) begin
      q.delete();
    end else begin
      if (xf) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  // add x(10+k), x1, x2 with rs1=100+k, rs2=k
  task automatic present(input int k);
    drive(1'b1, 32'h0020_8033 | (32'(10 + k) << 7), 32'h0, 32'(100 + k), 32'(k));
  endtask

  function automatic exp_t add_exp(input int k);
    return {32'(100 + k), 32'(k), 4'h0, 5'(10 + k), 1'b1, 1'b0};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    ifc.i_flush = 1'b0;
    ifc.i_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle();
    cycle();
    tests_run++;
    if (ifc.o_in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", ifc.o_in_ready); end
    tests_run++;
    if (ifc.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ifc.o_valid); end
    tests_run++;
    if (got() !== exp_t'(0)) begin fails++; $display("FAIL reset_payload: got %h want 0", got()); end
    i_rst = 1'b0;
    cycle();
    tests_run++;
    if (ifc.o_in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", ifc.o_in_ready); end
    tests_run++;
    if (ifc.o_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b want 0", ifc.o_valid); end
    tests_run++;
    if (got() !== exp_t'(0)) begin fails++; $display("FAIL post_reset_payload: got %h want 0", got()); end
  endtask

  task automatic test_decode();
    vec_t v[9];
    v[0] = '{"add",      32'h0020_81B3, 32'h0,   32'd5,         32'd7,    {32'd5,         32'd7,         4'h0, 5'd3, 1'b1, 1'b0}};
    v[1] = '{"srai",     32'h4043_5293, 32'h0,   32'h8000_0000, 32'h55,   {32'h8000_0000, 32'd4,         4'h7, 5'd5, 1'b1, 1'b0}};
    v[2] = '{"sll",      32'h0031_10B3, 32'h0,   32'h11,        32'h123,  {32'h11,        32'h3,         4'h2, 5'd1, 1'b1, 1'b0}};
    v[3] = '{"lui_x0",   32'h1234_5037, 32'h0,   32'h77,        32'h88,   {32'h0,         32'h1234_5000, 4'hF, 5'd0, 1'b0, 1'b0}};
    v[4] = '{"auipc",    32'h0000_1217, 32'h100, 32'h77,        32'h88,   {32'h100,       32'h1000,      4'h0, 5'd4, 1'b1, 1'b0}};
    v[5] = '{"branch",   32'h0020_8463, 32'h40,  32'h77,        32'h88,   {32'h0,         32'h0,         4'hF, 5'd8, 1'b0, 1'b1}};
    v[6] = '{"add_f7_1", 32'h0220_81B3, 32'h0,   32'd5,         32'd7,    {32'h0,         32'h0,         4'hF, 5'd3, 1'b0, 1'b1}};
    v[7] = '{"addi_neg", 32'hFFF0_8393, 32'h0,   32'd10,        32'h99,   {32'd10,        32'hFFFF_FFFF, 4'h0, 5'd7, 1'b1, 1'b0}};
    v[8] = '{"sub",      32'h4020_81B3, 32'h0,   32'd9,         32'd4,    {32'd9,         32'd4,         4'h1, 5'd3, 1'b1, 1'b0}};
    ifc.i_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, v[i].inst, v[i].pc, v[i].rs1, v[i].rs2);
      cycle();
      tests_run++;
      if (ifc.o_valid !== 1'b1) begin fails++; $display("FAIL %s_valid: got %b want 1", v[i].name, ifc.o_valid); end
      tests_run++;
      if (got() !== v[i].e) begin fails++; $display("FAIL %s_payload: got %h want %h", v[i].name, got(), v[i].e); end
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      cycle();
      tests_run++;
      if (ifc.o_valid !== 1'b0) begin fails++; $display("FAIL %s_drain: got %b want 0", v[i].name, ifc.o_valid); end
    end
  endtask

  task automatic test_back_to_back();
    ifc.i_ready = 1'b0;
    present(0);
    tests_run++;
    if (ifc.o_in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0: got %b want 1", ifc.o_in_ready); end
    cycle();
    present(1);
    tests_run++;
    if (ifc.o_in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %b want 1", ifc.o_in_ready); end
    cycle();
    present(2);
    tests_run++;
    if (ifc.o_in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: got %b want 0", ifc.o_in_ready); end
    cycle();
    tests_run++;
    if (ifc.o_in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_hold: got %b want 0", ifc.o_in_ready); end
    tests_run++;
    if (got() !== add_exp(0)) begin fails++; $display("FAIL b2b_stall_hold: got %h want %h", got(), add_exp(0)); end
    ifc.i_ready = 1'b1;
    cycle();
    tests_run++;
    if (got() !== add_exp(1) || ifc.o_valid !== 1'b1) begin fails++; $display("FAIL b2b_out1: got %h want %h", got(), add_exp(1)); end
    tests_run++;
    if (ifc.o_in_ready !== 1'b1) begin fails++; $display("FAIL b2b_reopen: got %b want 1", ifc.o_in_ready); end
    cycle();
    tests_run++;
    if (got() !== add_exp(2) || ifc.o_valid !== 1'b1) begin fails++; $display("FAIL b2b_out2: got %h want %h", got(), add_exp(2)); end
    present(3);
    cycle();
    tests_run++;
    if (got() !== add_exp(3) || ifc.o_valid !== 1'b1) begin fails++; $display("FAIL b2b_out3: got %h want %h", got(), add_exp(3)); end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle();
    tests_run++;
    if (ifc.o_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b want 0", ifc.o_valid); end
  endtask

  task automatic test_flush();
    ifc.i_ready = 1'b0;
    present(0); cycle();
    present(1); cycle();
    ifc.i_flush = 1'b1;
    present(2);
    cycle();
    ifc.i_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tests_run++;
    if (ifc.o_valid !== 1'b0) begin fails++; $display("FAIL flush_full_valid: got %b want 0", ifc.o_valid); end
    tests_run++;
    if (ifc.o_in_ready !== 1'b1) begin fails++; $display("FAIL flush_full_ready: got %b want 1", ifc.o_in_ready); end
    ifc.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (ifc.o_valid !== 1'b0) begin fails++; $display("FAIL flush_stale%0d: got %b want 0", i, ifc.o_valid); end
    end
    // One entry held, flush races an accept that would otherwise land.
    ifc.i_ready = 1'b0;
    present(4); cycle();
    ifc.i_flush = 1'b1;
    present(5);
    cycle();
    ifc.i_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tests_run++;
    if (ifc.o_valid !== 1'b0) begin fails++; $display("FAIL flush_accept_valid: got %b want 0", ifc.o_valid); end
    ifc.i_ready = 1'b1;
    cycle();
    tests_run++;
    if (ifc.o_valid !== 1'b0) begin fails++; $display("FAIL flush_accept_stale: got %b want 0", ifc.o_valid); end
  endtask

  task automatic test_reset_midstream();
    ifc.i_ready = 1'b0;
    present(6); cycle();
    present(7); cycle();
    present(8);
    i_rst = 1'b1;
    #1;
    tests_run++;
    if (ifc.o_in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_ready_now: got %b want 0", ifc.o_in_ready); end
    cycle();
    tests_run++;
    if (ifc.o_in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_ready: got %b want 0", ifc.o_in_ready); end
    tests_run++;
    if (ifc.o_valid !== 1'b0 || got() !== exp_t'(0)) begin fails++; $display("FAIL rst_mid_clear: got v=%b %h want v=0 0", ifc.o_valid, got()); end
    i_rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    ifc.i_ready = 1'b1;
    cycle();
    tests_run++;
    if (ifc.o_in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_after_ready: got %b want 1", ifc.o_in_ready); end
    tests_run++;
    if (ifc.o_valid !== 1'b0 || got() !== exp_t'(0)) begin fails++; $display("FAIL rst_mid_after: got v=%b %h want v=0 0", ifc.o_valid, got()); end
  endtask

  task automatic test_random_stream();
    q.delete();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom, $urandom);
      ifc.i_ready = ($urandom_range(0, 9) < 6);
      ifc.i_flush = ($urandom_range(0, 49) == 0);
      cycle();
      tests_run++;
      if (ifc.o_valid !== (q.size() != 0)) begin fails++; $display("FAIL rand_valid[%0d]: got %b want %b", n, ifc.o_valid, q.size() != 0); end
      tests_run++;
      if (ifc.o_in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, ifc.o_in_ready, q.size() < 2); end
      if (q.size() != 0) begin
        tests_run++;
        if (got() !== q[0]) begin fails++; $display("FAIL rand_payload[%0d]: got %h want %h", n, got(), q[0]); end
      end
    end
    ifc.i_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
